// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM: per-state datapath strobes/muxes,
// memory wait-state handshake, optional retire counter (RETIRE_CNT_EN).
// Ports:
//   clk, rst_n           clock and async active-low reset
//   opcode, funct3, EQ   instruction fields and ALU zero flag
//   mem_ready            memory access completes this cycle
//   MemReq..ResultSrc    datapath strobes and mux selects
//   illegal, state       ILLEGAL indicator, current state (debug)
//   instret              retired-instruction count (0 unless RETIRE_CNT_EN)
module multicycle_ctrl #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             EQ,
  input  logic             mem_ready,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUsrcA,
  output logic [1:0]       ALUsrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUctrl,
  output logic [1:0]       ResultSrc,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECI    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_JAL      = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_ILLEGAL  = 4'd15;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  logic [3:0] next;
  logic       imm_ok;
  logic       br_ok;

  assign imm_ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                  (funct3 == 3'b110) || (funct3 == 3'b010);
  assign br_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next;
  end

  always_comb begin
    next      = state;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUsrcA   = 2'b00;
    ALUsrcB   = 2'b00;
    ImmSrc    = 2'b00;
    ALUctrl   = 3'b000;
    ResultSrc = 2'b00;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUsrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) next = S_DECODE;
      end
      S_DECODE: begin
        // ALU forms OldPC+imm here so JAL/branch targets are ready early
        ALUsrcA = 2'b01;
        ALUsrcB = 2'b01;
        ImmSrc  = (opcode == OP_JAL) ? 2'b11 : 2'b10;
        unique case (1'b1)
          (opcode == OP_LOAD),
          (opcode == OP_STORE):          next = S_MEMADR;
          (opcode == OP_IMM) && imm_ok:  next = S_EXECI;
          (opcode == OP_JAL):            next = S_JAL;
          (opcode == OP_BR) && br_ok:    next = S_BRANCH;
          default:                       next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUsrcA = 2'b10;
        ALUsrcB = 2'b01;
        if (opcode == OP_STORE) begin
          ImmSrc = 2'b01;
          next   = S_MEMWRITE;
        end else begin
          next   = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready) next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        next      = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) next = S_FETCH;
      end
      S_EXECI: begin
        ALUsrcA = 2'b10;
        ALUsrcB = 2'b01;
        unique case (1'b1)
          (funct3 == 3'b111): ALUctrl = 3'b010;
          (funct3 == 3'b110): ALUctrl = 3'b011;
          (funct3 == 3'b010): ALUctrl = 3'b101;
          default:            ALUctrl = 3'b000;
        endcase
        next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        next     = S_FETCH;
      end
      S_JAL: begin
        // PC takes the DECODE target; ALU forms OldPC+4 for the link
        ALUsrcA = 2'b01;
        ALUsrcB = 2'b10;
        PCWrite = 1'b1;
        next    = S_ALUWB;
      end
      S_BRANCH: begin
        ALUsrcA = 2'b10;
        ALUctrl = 3'b001;
        unique case (1'b1)
          (funct3 == 3'b000): PCWrite = EQ;
          (funct3 == 3'b001): PCWrite = !EQ;
          default:            PCWrite = 1'b0;
        endcase
        next = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        next    = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      end
      default: next = S_FETCH;
    endcase
    // reset must kill strobes combinationally, not at the next edge
    if (!rst_n) begin
      MemReq   = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

`ifdef RETIRE_CNT_EN
  logic retire;

  assign retire = (state == S_MEMWB) ||
                  (state == S_ALUWB) ||
                  (state == S_BRANCH) ||
                  ((state == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected output bundles queued per
// step and popped for comparison at the following negedge.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

`ifdef RETIRE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        EQ;
  logic        mem_ready;
  logic        MemReq, MemWrite, AdrSrc;
  logic        IRWrite, PCWrite, RegWrite;
  logic [1:0]  ALUsrcA, ALUsrcB, ImmSrc, ResultSrc;
  logic [2:0]  ALUctrl;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] instret;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .EQ(EQ), .mem_ready(mem_ready), .MemReq(MemReq),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUsrcA(ALUsrcA),
    .ALUsrcB(ALUsrcB), .ImmSrc(ImmSrc), .ALUctrl(ALUctrl),
    .ResultSrc(ResultSrc), .illegal(illegal), .state(state),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] v;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          ret    = 0;
  logic [21:0] obs;

  assign obs = {state, MemReq, MemWrite, AdrSrc, IRWrite, PCWrite,
                RegWrite, ALUsrcA, ALUsrcB, ImmSrc, ALUctrl,
                ResultSrc, illegal};

  function automatic logic [21:0] mk(
    input logic [3:0] st, input logic mq, input logic mw,
    input logic as, input logic irw, input logic pcw,
    input logic rw, input logic [1:0] a, input logic [1:0] b,
    input logic [1:0] imm, input logic [2:0] ctl,
    input logic [1:0] res, input logic ill);
    return {st, mq, mw, as, irw, pcw, rw, a, b, imm, ctl, res, ill};
  endfunction

  function automatic logic [21:0] e_rst();
    return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10, 0);
  endfunction
  function automatic logic [21:0] e_fetch(input logic mr);
    return mk(0, 1, 0, 0, mr, mr, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10, 0);
  endfunction
  function automatic logic [21:0] e_dec(input logic j);
    return mk(1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, j ? 2'b11 : 2'b10,
              3'b000, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_madr(input logic st);
    return mk(2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, st ? 2'b01 : 2'b00,
              3'b000, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_mrd();
    return mk(3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_mwb();
    return mk(4, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0);
  endfunction
  function automatic logic [21:0] e_mwr();
    return mk(5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_exe(input logic [2:0] c);
    return mk(6, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, c, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_awb();
    return mk(7, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_jal();
    return mk(8, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_br(input logic p);
    return mk(9, 0, 0, 0, 0, p, 0, 2'b10, 2'b00, 2'b00, 3'b001, 2'b00, 0);
  endfunction
  function automatic logic [21:0] e_ill();
    return mk(15, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1);
  endfunction

  task automatic check_out();
    exp_t x;
    x = sb.pop_front();
    checks++;
    assert (obs === x.v) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", x.tag, obs, x.v);
    end
  endtask

  // called just after a posedge; checks at the negedge, returns after
  // the next posedge
  task automatic step(input logic mr, input logic [6:0] op,
                      input logic [2:0] f3, input logic eq,
                      input logic [21:0] e, input string tag);
    mem_ready = mr;
    opcode    = op;
    funct3    = f3;
    EQ        = eq;
    sb.push_back('{e, tag});
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    logic [31:0] want;
    want = CNT_ON ? 32'(ret) : 32'd0;
    checks++;
    assert (instret === want) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, instret, want);
    end
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    sb.push_back('{e_rst(), tag});
    check_out();
    ret = 0;
    chk_cnt({tag, "_cnt"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = OP_IMM;
    funct3 = 3'b000;
    EQ = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    reset_pulse("reset");

    // ADDI, mem_ready ignored outside memory states
    step(1, OP_IMM, 3'b000, 0, e_fetch(1), "addi_fetch");
    step(0, OP_IMM, 3'b000, 0, e_dec(0),   "addi_dec");
    step(0, OP_IMM, 3'b000, 0, e_exe(3'b000), "addi_exe");
    step(0, OP_IMM, 3'b000, 0, e_awb(),    "addi_wb");
    ret++;

    // SLTI with one fetch wait state
    step(0, OP_IMM, 3'b010, 0, e_fetch(0), "slti_fetch_wait");
    step(1, OP_IMM, 3'b010, 0, e_fetch(1), "slti_fetch");
    step(1, OP_IMM, 3'b010, 0, e_dec(0),   "slti_dec");
    step(1, OP_IMM, 3'b010, 0, e_exe(3'b101), "slti_exe");
    step(1, OP_IMM, 3'b010, 0, e_awb(),    "slti_wb");
    ret++;

    // ANDI and ORI decode to and/or
    step(1, OP_IMM, 3'b111, 0, e_fetch(1), "andi_fetch");
    step(1, OP_IMM, 3'b111, 0, e_dec(0),   "andi_dec");
    step(1, OP_IMM, 3'b111, 0, e_exe(3'b010), "andi_exe");
    step(1, OP_IMM, 3'b111, 0, e_awb(),    "andi_wb");
    ret++;
    step(1, OP_IMM, 3'b110, 0, e_fetch(1), "ori_fetch");
    step(1, OP_IMM, 3'b110, 0, e_dec(0),   "ori_dec");
    step(1, OP_IMM, 3'b110, 0, e_exe(3'b011), "ori_exe");
    step(1, OP_IMM, 3'b110, 0, e_awb(),    "ori_wb");
    ret++;
    chk_cnt("cnt_alu");

    // LW with two read wait states
    step(1, OP_LOAD, 3'b010, 0, e_fetch(1), "lw_fetch");
    step(1, OP_LOAD, 3'b010, 0, e_dec(0),   "lw_dec");
    step(0, OP_LOAD, 3'b010, 0, e_madr(0),  "lw_adr");
    step(0, OP_LOAD, 3'b010, 0, e_mrd(),    "lw_rd_wait1");
    step(0, OP_LOAD, 3'b010, 0, e_mrd(),    "lw_rd_wait2");
    step(1, OP_LOAD, 3'b010, 0, e_mrd(),    "lw_rd");
    step(0, OP_LOAD, 3'b010, 0, e_mwb(),    "lw_wb");
    ret++;

    // SW with one write wait state
    step(1, OP_STORE, 3'b010, 0, e_fetch(1), "sw_fetch");
    step(1, OP_STORE, 3'b010, 0, e_dec(0),   "sw_dec");
    step(1, OP_STORE, 3'b010, 0, e_madr(1),  "sw_adr");
    step(0, OP_STORE, 3'b010, 0, e_mwr(),    "sw_wr_wait");
    chk_cnt("cnt_sw_wait");
    step(1, OP_STORE, 3'b010, 0, e_mwr(),    "sw_wr");
    ret++;
    chk_cnt("cnt_sw");

    // BNE taken/not taken, BEQ taken and not taken
    step(1, OP_BR, 3'b001, 1, e_fetch(1), "bne1_fetch");
    step(1, OP_BR, 3'b001, 1, e_dec(0),   "bne1_dec");
    step(1, OP_BR, 3'b001, 1, e_br(0),    "bne_eq1");
    ret++;
    step(1, OP_BR, 3'b001, 0, e_fetch(1), "bne2_fetch");
    step(1, OP_BR, 3'b001, 0, e_dec(0),   "bne2_dec");
    step(1, OP_BR, 3'b001, 0, e_br(1),    "bne_eq0");
    ret++;
    step(1, OP_BR, 3'b000, 1, e_fetch(1), "beq1_fetch");
    step(1, OP_BR, 3'b000, 1, e_dec(0),   "beq1_dec");
    step(1, OP_BR, 3'b000, 1, e_br(1),    "beq_eq1");
    ret++;
    step(1, OP_BR, 3'b000, 0, e_fetch(1), "beq2_fetch");
    step(1, OP_BR, 3'b000, 0, e_dec(0),   "beq2_dec");
    step(1, OP_BR, 3'b000, 0, e_br(0),    "beq_eq0");
    ret++;

    // JAL: 4 cycles
    step(1, OP_JAL, 3'b000, 0, e_fetch(1), "jal_fetch");
    step(1, OP_JAL, 3'b000, 0, e_dec(1),   "jal_dec");
    step(1, OP_JAL, 3'b000, 0, e_jal(),    "jal_jal");
    step(1, OP_JAL, 3'b000, 0, e_awb(),    "jal_wb");
    ret++;
    step(1, OP_JAL, 3'b000, 0, e_fetch(1), "post_jal_fetch");
    chk_cnt("cnt_all");

    // illegal opcode halts, not counted
    step(1, OP_LUI, 3'b000, 0, e_dec(0), "lui_dec");
    for (int i = 0; i < 10; i++)
      step(1, OP_LUI, 3'b000, 0, e_ill(), $sformatf("ill_hold%0d", i));
    chk_cnt("cnt_ill");
    reset_pulse("reset_ill");

    // OP-IMM with unsupported funct3 is illegal
    step(1, OP_IMM, 3'b001, 0, e_fetch(1), "slli_fetch");
    step(1, OP_IMM, 3'b001, 0, e_dec(0),   "slli_dec");
    step(1, OP_IMM, 3'b001, 0, e_ill(),    "slli_ill");
    reset_pulse("reset_slli");

    // branch with unsupported funct3 is illegal
    step(1, OP_BR, 3'b100, 0, e_fetch(1), "blt_fetch");
    step(1, OP_BR, 3'b100, 0, e_dec(0),   "blt_dec");
    step(1, OP_BR, 3'b100, 0, e_ill(),    "blt_ill");
    reset_pulse("reset_blt");

    // count one ADDI, then reset in the middle of a store
    step(1, OP_IMM, 3'b000, 0, e_fetch(1), "addi2_fetch");
    step(1, OP_IMM, 3'b000, 0, e_dec(0),   "addi2_dec");
    step(1, OP_IMM, 3'b000, 0, e_exe(3'b000), "addi2_exe");
    step(1, OP_IMM, 3'b000, 0, e_awb(),    "addi2_wb");
    ret++;
    chk_cnt("cnt_addi2");
    step(1, OP_STORE, 3'b000, 0, e_fetch(1), "sw2_fetch");
    step(1, OP_STORE, 3'b000, 0, e_dec(0),   "sw2_dec");
    step(1, OP_STORE, 3'b000, 0, e_madr(1),  "sw2_adr");
    mem_ready = 1'b0;
    @(negedge clk);
    sb.push_back('{e_mwr(), "sw2_wr_wait"});
    check_out();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (MemReq === 1'b0) else begin
      errors++;
      $error("FAIL midreset_memreq: got %b expected 0", MemReq);
    end
    checks++;
    assert (state === 4'd0) else begin
      errors++;
      $error("FAIL midreset_state: got %0d expected 0", state);
    end
    ret = 0;
    chk_cnt("midreset_cnt");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, OP_IMM, 3'b000, 0, e_fetch(1), "post_reset_fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
